// File: rtl/adc_ser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_ser_pkg
//  Description : Shared types and constants for the ADC sample serializer.
//                - ser_state_e : serializer FSM state encoding (2 bits)
//                - PAD_*       : bit positions of each serial pad in the
//                                3-bit pad control vectors
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } ser_state_e;

    localparam int NUM_SER_PADS = 3;
    localparam int PAD_SCLK     = 0;
    localparam int PAD_SDATA    = 1;
    localparam int PAD_FRAME    = 2;

endpackage : adc_ser_pkg
`default_nettype wire

// File: rtl/adc_sample_serializer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with registered occupancy count.
//                Pushes while full and pops while empty are ignored.
//                dout always shows the entry at the read pointer.
//  Ports       : clk, rst_n (async active-low)
//                push/din  - write side
//                pop/dout  - read side
//                full, empty, level (occupancy, 0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q,  level_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign level   = level_q;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/adc_sample_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_serializer
//  Description : Buffers parallel ADC samples in a small FIFO and shifts each
//                one out MSB-first with a generated serial clock and a frame
//                strobe, driving three bidirectional output pads.
//  Ports       : clk, rst_n (async active-low)
//                enable                - serializer enable, also pad OE
//                s_data/s_valid/s_ready- sample input (s_ready = !full)
//                clear_ovf             - clears the sticky overflow flag
//                sclk_o/sdata_o/frame_o- serial word outputs
//                pad_oe_o/_sl_o/_cs_o/_ie_o - pad controls {frame,sdata,sclk}
//                overflow_o            - a sample was dropped
//                fifo_level_o          - FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_serializer
    import adc_ser_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          clear_ovf,
    output logic                          sclk_o,
    output logic                          sdata_o,
    output logic                          frame_o,
    output logic [NUM_SER_PADS-1:0]       pad_oe_o,
    output logic [NUM_SER_PADS-1:0]       pad_sl_o,
    output logic [NUM_SER_PADS-1:0]       pad_cs_o,
    output logic [NUM_SER_PADS-1:0]       pad_ie_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    // div_cnt also times the inter-word gap, so it must reach 2*CLK_DIV-1.
    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [DIV_W-1:0] HALF_TC  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_TC   = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    ser_state_e              state_q,    state_d;
    logic [DIV_W-1:0]        div_cnt_q,  div_cnt_d;
    logic [CNT_W-1:0]        bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q,    shift_d;
    logic                    sclk_q,     sclk_d;
    logic                    frame_q,    frame_d;
    logic                    pad_oe_q,   pad_oe_d;
    logic                    overflow_q, overflow_d;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DATA_WIDTH-1:0]   fifo_dout;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (s_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level_o)
    );

    // Refusing pushes purely on full means a same-cycle pop never frees a slot.
    assign s_ready   = !fifo_full;
    assign fifo_push = s_valid && s_ready;

    // The producer cannot stall, so a refused sample is lost; set beats clear.
    always_comb begin
        overflow_d = overflow_q;
        if (s_valid && !s_ready) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    assign pad_oe_d = enable;

    // The shift register MSB is the serial data line; after the last bit the
    // register is left unshifted so the line holds its final value while idle.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sclk_d    = sclk_q;
        frame_d   = frame_q;
        fifo_pop  = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d  = 1'b0;
                frame_d = 1'b0;
                if (enable && !fifo_empty) begin
                    state_d = LOAD;
                end
            end

            LOAD: begin
                fifo_pop  = 1'b1;
                shift_d   = fifo_dout;
                bit_cnt_d = LAST_BIT;
                div_cnt_d = '0;
                sclk_d    = 1'b0;
                frame_d   = 1'b1;
                state_d   = SHIFT;
            end

            SHIFT: begin
                if (div_cnt_q == HALF_TC) begin
                    div_cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling sclk: advance to the next bit or end the word.
                        sclk_d = 1'b0;
                        if (bit_cnt_q == '0) begin
                            frame_d = 1'b0;
                            state_d = GAP;
                        end else begin
                            shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q - CNT_W'(1);
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end

            GAP: begin
                sclk_d  = 1'b0;
                frame_d = 1'b0;
                if (div_cnt_q == GAP_TC) begin
                    div_cnt_d = '0;
                    if (enable && !fifo_empty) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            sclk_q     <= 1'b0;
            frame_q    <= 1'b0;
            pad_oe_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sclk_q     <= sclk_d;
            frame_q    <= frame_d;
            pad_oe_q   <= pad_oe_d;
            overflow_q <= overflow_d;
        end
    end

    assign sclk_o     = sclk_q;
    assign sdata_o    = shift_q[DATA_WIDTH-1];
    assign frame_o    = frame_q;
    assign overflow_o = overflow_q;

    always_comb begin
        pad_oe_o            = '0;
        pad_oe_o[PAD_SCLK]  = pad_oe_q;
        pad_oe_o[PAD_SDATA] = pad_oe_q;
        pad_oe_o[PAD_FRAME] = pad_oe_q;
    end

    assign pad_sl_o = '0;
    assign pad_cs_o = '0;
    assign pad_ie_o = '0;

endmodule : adc_sample_serializer
`default_nettype wire

// File: tb/tb_adc_sample_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_sample_serializer
//  Description : Self-checking bench for adc_sample_serializer. A serial
//                receiver observes the wire and records each word; expected
//                words, lengths and timings come from the bench's own tables
//                and a word-level scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_sample_serializer;

    localparam int DW   = 16;
    localparam int CD   = 2;
    localparam int WORD_CYC = DW * 2 * CD;     // frame-high cycles per word
    localparam int GAP_LOW  = 2 * CD + 1;      // gap state plus the load cycle

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 16-bit words, CLK_DIV=2
    logic        rst_n, enable, s_valid, clear_ovf;
    logic [15:0] s_data;
    logic        s_ready, sclk_o, sdata_o, frame_o, overflow_o;
    logic [2:0]  pad_oe_o, pad_sl_o, pad_cs_o, pad_ie_o, fifo_level_o;

    // DUT B: 8-bit words, CLK_DIV=1
    logic        b_enable, b_valid, b_clear;
    logic [7:0]  b_data;
    logic        b_ready, b_sclk, b_sdata, b_frame, b_ovf;
    logic [2:0]  b_oe, b_sl, b_cs, b_ie, b_level;

    adc_sample_serializer #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .s_data(s_data),
        .s_valid(s_valid), .s_ready(s_ready), .clear_ovf(clear_ovf),
        .sclk_o(sclk_o), .sdata_o(sdata_o), .frame_o(frame_o),
        .pad_oe_o(pad_oe_o), .pad_sl_o(pad_sl_o), .pad_cs_o(pad_cs_o),
        .pad_ie_o(pad_ie_o), .overflow_o(overflow_o), .fifo_level_o(fifo_level_o)
    );

    adc_sample_serializer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(b_enable), .s_data(b_data),
        .s_valid(b_valid), .s_ready(b_ready), .clear_ovf(b_clear),
        .sclk_o(b_sclk), .sdata_o(b_sdata), .frame_o(b_frame),
        .pad_oe_o(b_oe), .pad_sl_o(b_sl), .pad_cs_o(b_cs),
        .pad_ie_o(b_ie), .overflow_o(b_ovf), .fifo_level_o(b_level)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Serial receiver for DUT A: captures sdata on each sclk rising edge
    // while frame is high and logs finished words.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] data;
        int          flen;
        int          rises;
        int          lowrun;
    } rx_t;

    rx_t         rx_mem [128];
    int          rx_wr = 0;
    int          rx_rd = 0;
    logic        m_in = 1'b0;
    logic        m_prev_sclk = 1'b0;
    logic [31:0] m_bits = '0;
    int          m_flen = 0;
    int          cur_rises = 0;
    int          m_low = 0;
    int          m_lowrun = 0;
    int          act_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_in        = 1'b0;
            m_prev_sclk = 1'b0;
            m_low       = 0;
            cur_rises   = 0;
            act_cnt     = 0;
        end else begin
            if (sclk_o || frame_o) act_cnt++;
            if (frame_o) begin
                if (!m_in) begin
                    m_in      = 1'b1;
                    m_bits    = '0;
                    m_flen    = 0;
                    cur_rises = 0;
                    m_lowrun  = m_low;
                end
                m_flen++;
                if (sclk_o && !m_prev_sclk) begin
                    m_bits = {m_bits[30:0], sdata_o};
                    cur_rises++;
                end
            end else begin
                if (m_in) begin
                    rx_mem[rx_wr % 128] = '{m_bits, m_flen, cur_rises, m_lowrun};
                    rx_wr++;
                    m_in  = 1'b0;
                    m_low = 0;
                end
                m_low++;
            end
            m_prev_sclk = sclk_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        int cyc = 0;
        while ((rx_wr - rx_rd) < n && cyc < budget) begin
            tick(1);
            cyc++;
        end
        if ((rx_wr - rx_rd) < n) check(name, 64'(rx_wr - rx_rd), 64'(n));
    endtask

    task automatic get_word(output rx_t w);
        if (rx_wr > rx_rd) begin
            w = rx_mem[rx_rd % 128];
            rx_rd++;
        end else begin
            w = '{32'hDEAD_BEEF, -1, -1, -1};
        end
    endtask

    task automatic push_words(input logic [15:0] d [$]);
        s_valid = 1'b1;
        foreach (d[i]) begin
            s_data = d[i];
            tick(1);
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_mid_word(input int nbits, input string name);
        int cyc = 0;
        while (!(m_in && cur_rises >= nbits) && cyc < 300) begin
            tick(1);
            cyc++;
        end
        if (!(m_in && cur_rises >= nbits)) check(name, 64'(cur_rises), 64'(nbits));
    endtask

    typedef struct {
        logic [15:0] data;
        int          lat;
        int          flen;
        int          rises;
    } vec_t;

    vec_t        vecs [5];
    rx_t         w;
    logic [15:0] q [$];
    logic [15:0] exp_q [$];
    int          lat, peak, pushed, base;
    int          flen, rises, tog, cyc;
    logic        prev;
    logic [7:0]  bbits;

    initial begin
        vecs[0] = '{16'hA5C3, 2, WORD_CYC, DW};
        vecs[1] = '{16'h0001, 2, WORD_CYC, DW};
        vecs[2] = '{16'h8000, 2, WORD_CYC, DW};
        vecs[3] = '{16'hFFFF, 2, WORD_CYC, DW};
        vecs[4] = '{16'h0000, 2, WORD_CYC, DW};

        rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; clear_ovf = 1'b0; s_data = '0;
        b_enable = 1'b0; b_valid = 1'b0; b_clear = 1'b0; b_data = '0;
        #12;

        // ---- reset state ----
        check("rst_sclk",   64'(sclk_o), 0);
        check("rst_sdata",  64'(sdata_o), 0);
        check("rst_frame",  64'(frame_o), 0);
        check("rst_oe",     64'(pad_oe_o), 0);
        check("rst_ovf",    64'(overflow_o), 0);
        check("rst_level",  64'(fifo_level_o), 0);
        check("rst_ready",  64'(s_ready), 1);
        check("pad_consts", 64'({pad_sl_o, pad_cs_o, pad_ie_o}), 0);

        @(posedge clk); #1;
        rst_n = 1'b1; enable = 1'b1; b_enable = 1'b1;
        tick(1);
        check("oe_on", 64'(pad_oe_o), 64'(3'b111));

        // ---- single words from the table ----
        for (int i = 0; i < 5; i++) begin
            q = '{vecs[i].data};
            push_words(q);
            lat = 0;
            while (!frame_o && lat < 10) begin
                tick(1);
                lat++;
            end
            check($sformatf("lat[%0d]", i), 64'(lat), 64'(vecs[i].lat));
            wait_words(1, 200, "single_timeout");
            get_word(w);
            check($sformatf("data[%0d]", i),  64'(w.data),  64'(vecs[i].data));
            check($sformatf("flen[%0d]", i),  64'(w.flen),  64'(vecs[i].flen));
            check($sformatf("rises[%0d]", i), 64'(w.rises), 64'(vecs[i].rises));
            tick(10);
        end

        // ---- back-to-back ----
        q = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1234};
        peak = 0;
        s_valid = 1'b1;
        foreach (q[i]) begin
            s_data = q[i];
            tick(1);
            if (int'(fifo_level_o) > peak) peak = int'(fifo_level_o);
        end
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (int'(fifo_level_o) > peak) peak = int'(fifo_level_o);
        end
        check("b2b_peak", 64'(peak), 3);
        wait_words(4, 400, "b2b_timeout");
        foreach (q[i]) begin
            get_word(w);
            check($sformatf("b2b_data[%0d]", i), 64'(w.data), 64'(q[i]));
            if (i > 0) check($sformatf("b2b_gap[%0d]", i), 64'(w.lowrun), 64'(GAP_LOW));
        end
        check("b2b_ovf", 64'(overflow_o), 0);
        tick(10);

        // ---- overflow ----
        enable = 1'b0;
        q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = q[i];
            tick(1);
            if (i == 3) begin
                check("ovf_ready_full", 64'(s_ready), 0);
                check("ovf_not_yet", 64'(overflow_o), 0);
            end
        end
        s_valid = 1'b0;
        check("ovf_set", 64'(overflow_o), 1);
        check("ovf_level", 64'(fifo_level_o), 4);
        enable = 1'b1;
        wait_words(4, 400, "ovf_timeout");
        for (int i = 0; i < 4; i++) begin
            get_word(w);
            check($sformatf("ovf_data[%0d]", i), 64'(w.data), 64'(q[i]));
        end
        tick(150);
        check("ovf_no_fifth", 64'(rx_wr - rx_rd), 0);
        clear_ovf = 1'b1;
        tick(1);
        clear_ovf = 1'b0;
        check("ovf_clear", 64'(overflow_o), 0);

        // ---- set and clear in the same cycle ----
        enable = 1'b0;
        q = '{16'hC001, 16'hC002, 16'hC003, 16'hC004};
        push_words(q);
        s_valid = 1'b1; s_data = 16'hBAD0; clear_ovf = 1'b1;
        tick(1);
        s_valid = 1'b0;
        check("ovf_set_wins", 64'(overflow_o), 1);
        tick(1);
        clear_ovf = 1'b0;
        check("ovf_clear2", 64'(overflow_o), 0);
        enable = 1'b1;
        wait_words(4, 400, "sw_timeout");
        for (int i = 0; i < 4; i++) begin
            get_word(w);
            check($sformatf("sw_data[%0d]", i), 64'(w.data), 64'(q[i]));
        end
        tick(10);

        // ---- enable drop mid-word ----
        q = '{16'hE1E1, 16'hE2E2, 16'hE3E3};
        push_words(q);
        wait_mid_word(8, "en_bit8_timeout");
        enable = 1'b0;
        check("en_oe_still", 64'(pad_oe_o), 64'(3'b111));
        tick(1);
        check("en_oe_drop", 64'(pad_oe_o), 0);
        wait_words(1, 200, "en_timeout");
        get_word(w);
        check("en_data",  64'(w.data),  64'(16'hE1E1));
        check("en_rises", 64'(w.rises), 64'(DW));
        check("en_flen",  64'(w.flen),  64'(WORD_CYC));
        tick(150);
        check("en_no_more", 64'(rx_wr - rx_rd), 0);
        check("en_level",   64'(fifo_level_o), 2);
        enable = 1'b1;
        wait_words(2, 400, "en_drain_timeout");
        for (int i = 1; i < 3; i++) begin
            get_word(w);
            check($sformatf("en_drain[%0d]", i), 64'(w.data), 64'(q[i]));
        end
        tick(10);

        // ---- reset mid-word ----
        q = '{16'h7E57, 16'h0F0F, 16'hF0F0};
        push_words(q);
        wait_mid_word(5, "rst_bit5_timeout");
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_sclk",  64'(sclk_o), 0);
        check("mid_rst_frame", 64'(frame_o), 0);
        check("mid_rst_sdata", 64'(sdata_o), 0);
        check("mid_rst_level", 64'(fifo_level_o), 0);
        check("mid_rst_oe",    64'(pad_oe_o), 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        tick(200);
        check("post_rst_words", 64'(rx_wr - rx_rd), 0);
        check("post_rst_act",   64'(act_cnt), 0);
        check("post_rst_level", 64'(fifo_level_o), 0);

        // ---- randomized traffic against the word scoreboard ----
        base = rx_wr;
        pushed = 0;
        for (int n = 0; n < 12; n++) begin
            cyc = 0;
            // Words not yet fully received bound the FIFO occupancy from above.
            while ((pushed - (rx_wr - base)) >= 4 && cyc < 500) begin
                tick(1);
                cyc++;
            end
            check($sformatf("rnd_ready[%0d]", n), 64'(s_ready), 1);
            exp_q.push_back(16'($urandom));
            q = '{exp_q[n]};
            push_words(q);
            pushed++;
            tick($urandom_range(0, 30));
        end
        wait_words(12, 1500, "rnd_timeout");
        for (int n = 0; n < 12; n++) begin
            get_word(w);
            check($sformatf("rnd_data[%0d]", n), 64'(w.data), 64'(exp_q[n]));
            check($sformatf("rnd_flen[%0d]", n), 64'(w.flen), 64'(WORD_CYC));
        end
        check("rnd_ovf", 64'(overflow_o), 0);

        // ---- fast divider (DUT B: 8 bits, CLK_DIV=1) ----
        b_valid = 1'b1; b_data = 8'h5A;
        tick(1);
        b_valid = 1'b0;
        cyc = 0;
        while (!b_frame && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        flen = 0; rises = 0; tog = 0; prev = 1'b0; bbits = '0;
        while (b_frame && flen < 100) begin
            flen++;
            if (b_sclk !== prev) tog++;
            if (b_sclk && !prev) begin
                rises++;
                bbits = {bbits[6:0], b_sdata};
            end
            prev = b_sclk;
            @(negedge clk);
        end
        check("fast_flen",  64'(flen), 16);
        check("fast_rises", 64'(rises), 8);
        check("fast_tog",   64'(tog), 15);
        check("fast_data",  64'(bbits), 64'(8'h5A));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_adc_sample_serializer
`default_nettype wire

// File: doc/adc_sample_serializer.md
Name: adc_sample_serializer

Overview:
- Output stage between the ADC sample path in the chip core and the bidirectional output pads.
- Accepts parallel ADC samples through a valid/ready interface and buffers them in a small FIFO.
- Shifts each sample out MSB-first as a serial word, with a generated serial clock and a frame strobe.
- Drives the data, output-enable and drive-strength controls of three bidir pads.

Parameters:
- DATA_WIDTH, 16: bits per sample word; legal range 2..32.
- FIFO_DEPTH, 4: sample buffer entries; power of 2, at least 2.
- CLK_DIV, 2: clk cycles per sclk half-period; at least 1.

Ports:
- clk  input  1  core clock, from the clock pad (Schmitt input).
- rst_n  input  1  asynchronous active-low reset, from the reset pad.
- enable  input  1  serializer enable; also gates pad output-enable.
- s_data  input  DATA_WIDTH  sample from the ADC datapath.
- s_valid  input  1  sample valid.
- s_ready  output  1  FIFO can accept; equals !full.
- clear_ovf  input  1  synchronous clear of overflow_o.
- sclk_o  output  1  serial clock to the bidir pad A input.
- sdata_o  output  1  serial data to the bidir pad A input.
- frame_o  output  1  high while a word is on the wire.
- pad_oe_o  output  3  OE for {frame, sdata, sclk} pads; all bits equal enable (registered).
- pad_sl_o  output  3  slew control; constant 0.
- pad_cs_o  output  3  Schmitt select; constant 0.
- pad_ie_o  output  3  input enable; constant 0.
- overflow_o  output  1  sticky flag: a sample was lost.
- fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst_n=0): FIFO empty; FSM in IDLE. All of sclk_o, sdata_o, frame_o, pad_oe_o, overflow_o and fifo_level_o are 0. s_ready is 1 combinationally from empty.
- Push: s_valid && s_ready writes the FIFO at the clk edge.
  - Push while full is refused, even if a pop happens in the same cycle.
- Overflow: s_valid && !s_ready sets overflow_o on the next edge (the producer cannot stall).
  - clear_ovf clears it.
  - If set and clear occur in the same cycle, set wins.
- Pop only in LOAD.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - sclk_o=0, frame_o=0, sdata_o holds its last value.
  - Moves to LOAD when enable=1 and the FIFO is not empty.
- LOAD (1 cycle):
  - Pops the head into the shift register; bit_cnt=DATA_WIDTH-1; div_cnt=0.
  - Next state is SHIFT.
  - Registered outputs in the following cycle: frame_o=1, sdata_o=MSB.
- SHIFT:
  - div_cnt counts 0..CLK_DIV-1; at the terminal count sclk_o toggles.
  - Rising sclk: the receiver samples.
  - Falling sclk: shift left and present the next bit, or, if bit_cnt==0, go to GAP.
  - Word length: DATA_WIDTH*2*CLK_DIV clk cycles with frame_o=1.
- GAP:
  - frame_o=0, sclk_o=0 for 2*CLK_DIV cycles.
  - Then LOAD if enable=1 and not empty, else IDLE.
- Latency: a push into an empty FIFO in IDLE at edge N gives LOAD in cycle N+1 and frame_o rising at edge N+2.
- enable deasserted mid-word: the current word completes, then the FSM returns to IDLE. pad_oe_o drops one cycle after enable falls; the bus may be truncated externally, which is accepted.
- Reset mid-word: immediate abort. Outputs return to reset values and the buffered samples are discarded.
- All outputs are registered, except s_ready and the constant pad controls.

Decomposition:
- Package adc_ser_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, GAP), 2 bits;
  - the pad index constants PAD_SCLK=0, PAD_SDATA=1, PAD_FRAME=2;
  - NUM_SER_PADS=3.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - ports: push/pop/din/dout, full/empty/level;
  - async active-low reset.
- The serializer FSM and shift register stay in the top module.

Test Plan:
- Single word: DATA_WIDTH=16, CLK_DIV=2, push 0xA5C3 while idle.
  - Required: frame_o high for exactly 64 cycles, starting 2 cycles after the push.
  - Bits captured on sclk rising edges read 0xA5C3.
  - 16 rising edges, then 4 GAP cycles with frame_o=0.
- Back-to-back: push 0x0001, 0x8000, 0xFFFF, 0x1234 on consecutive cycles.
  - Required: fifo_level_o peaks at 3 (one word already popped).
  - Words appear in order, each separated by exactly 4 GAP cycles, and overflow_o stays 0.
- Overflow: enable=0, push 5 words (FIFO_DEPTH=4).
  - Required: s_ready=0 after the 4th push and overflow_o=1 after the 5th.
  - After enable=1, exactly the first 4 words are emitted.
  - clear_ovf then returns overflow_o to 0.
- Enable drop: deassert enable at bit 8 of a word.
  - Required: the word still completes all 16 bits.
  - pad_oe_o=0 one cycle after enable falls.
  - The remaining FIFO entries are not popped.
- Reset mid-word: assert rst_n=0 at bit 5.
  - Required: sclk_o, frame_o, sdata_o and fifo_level_o are 0 immediately, with no clk edge needed.
  - After reset release, no output activity until a new push.
- Fast divider: CLK_DIV=1, DATA_WIDTH=8, push 0x5A.
  - Required: frame_o high for 16 cycles, sclk_o toggling every cycle, and received bits 0x5A.
